// File: rtl/tmds_video_tx.sv
// rtl/tmds_video_tx.sv - DVI/HDMI timing generator with 3-channel TMDS symbol encoder
module tmds_video_tx #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [23:0] rgb,
    output logic        pix_req,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic        frame_start,
    output logic [29:0] tmds,
    output logic        de_o,
    output logic        hsync_o,
    output logic        vsync_o
);

    localparam logic [15:0] HT     = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [15:0] VT     = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [15:0] HA     = 16'(H_ACTIVE);
    localparam logic [15:0] VA     = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  GB0    = 10'b1011001100;
    localparam logic [9:0]  GB1    = 10'b0100110011;

    typedef enum logic [1:0] {CLS_CTRL, CLS_PRE, CLS_GUARD, CLS_DATA} cls_t;

    function automatic logic [9:0] ctl_token(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic       xn;
        logic [8:0] q;
        int         n1;
        n1   = $countones(d);
        xn   = (n1 > 4) || (n1 == 4 && !d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~xn;
        return q;
    endfunction

    // Returns {next disparity, symbol}; disparity stays within +/-10 so 5 bits suffice.
    function automatic logic [14:0] tmds_bal(input logic [8:0] qm, input logic signed [4:0] cnt);
        int         n1, c;
        logic [9:0] q;
        n1 = $countones(qm[7:0]);
        c  = int'(cnt);
        if (c == 0 || n1 == 4) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            c = qm[8] ? c + 2 * n1 - 8 : c + 8 - 2 * n1;
        end else if ((c > 0 && n1 > 4) || (c < 0 && n1 < 4)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            c = c + (qm[8] ? 2 : 0) + 8 - 2 * n1;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            c = c - (qm[8] ? 0 : 2) + 2 * n1 - 8;
        end
        return {5'(c), q};
    endfunction

    logic [1:0] rst_sync;
    logic       srst_n;
    assign srst_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    logic [15:0] hcnt, vcnt;
    logic        running, next_active, hs0, vs0;
    cls_t        cls0;

    // A line only starts when en is high at hcnt==0; once started it always completes.
    always_comb begin
        running     = (hcnt != 16'd0) || en;
        next_active = (vcnt == VT - 16'd1) || (vcnt + 16'd1 < VA);
        hs0         = ~HS_POL;
        vs0         = ~VS_POL;
        cls0        = CLS_CTRL;
        if (running) begin
            if (hcnt >= HS_BEG && hcnt < HS_END) hs0 = HS_POL;
            if (vcnt >= VS_BEG && vcnt < VS_END) vs0 = VS_POL;
            if (hcnt < HA && vcnt < VA)                    cls0 = CLS_DATA;
            else if (next_active && hcnt >= HT - 16'd2)    cls0 = CLS_GUARD;
            else if (next_active && hcnt >= HT - 16'd10)   cls0 = CLS_PRE;
        end
    end

    assign pix_req     = srst_n && (cls0 == CLS_DATA);
    assign frame_start = srst_n && en && (hcnt == 16'd0) && (vcnt == 16'd0);
    assign pix_x       = hcnt;
    assign pix_y       = vcnt;

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            hcnt <= 16'd0;
            vcnt <= 16'd0;
        end else if (!running) begin
            hcnt <= 16'd0;
            vcnt <= 16'd0;
        end else if (hcnt == HT - 16'd1) begin
            hcnt <= 16'd0;
            vcnt <= (vcnt == VT - 16'd1) ? 16'd0 : vcnt + 16'd1;
        end else begin
            hcnt <= hcnt + 16'd1;
        end
    end

    cls_t              s1_cls, s2_cls;
    logic              s1_hs, s1_vs, s2_hs, s2_vs;
    logic [8:0]        s2_qm [3];
    logic signed [4:0] cnt [3];
    logic [14:0]       bal [3];
    logic [9:0]        sym [3];
    logic signed [4:0] cnt_d [3];

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            bal[n]   = tmds_bal(s2_qm[n], cnt[n]);
            sym[n]   = ctl_token(2'b00);
            cnt_d[n] = 5'sd0;
            case (s2_cls)
                CLS_DATA: begin
                    sym[n]   = bal[n][9:0];
                    cnt_d[n] = $signed(bal[n][14:10]);
                end
                CLS_GUARD: sym[n] = (n == 1) ? GB1 : GB0;
                CLS_PRE: begin
                    if (n == 0)      sym[n] = ctl_token({s2_vs, s2_hs});
                    else if (n == 1) sym[n] = ctl_token(2'b01);
                end
                default: if (n == 0) sym[n] = ctl_token({s2_vs, s2_hs});
            endcase
        end
    end

    // Stage 1 waits for rgb, stage 2 holds q_m, output register holds the balanced symbol.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            s1_cls  <= CLS_CTRL;
            s1_hs   <= ~HS_POL;
            s1_vs   <= ~VS_POL;
            s2_cls  <= CLS_CTRL;
            s2_hs   <= ~HS_POL;
            s2_vs   <= ~VS_POL;
            for (int n = 0; n < 3; n++) begin
                s2_qm[n] <= 9'd0;
                cnt[n]   <= 5'sd0;
            end
            tmds    <= {ctl_token(2'b00), ctl_token(2'b00), ctl_token({~VS_POL, ~HS_POL})};
            de_o    <= 1'b0;
            hsync_o <= ~HS_POL;
            vsync_o <= ~VS_POL;
        end else begin
            s1_cls  <= cls0;
            s1_hs   <= hs0;
            s1_vs   <= vs0;
            s2_cls  <= s1_cls;
            s2_hs   <= s1_hs;
            s2_vs   <= s1_vs;
            for (int n = 0; n < 3; n++) begin
                s2_qm[n] <= tmds_qm(rgb[8*n +: 8]);
                cnt[n]   <= cnt_d[n];
            end
            tmds    <= {sym[2], sym[1], sym[0]};
            de_o    <= (s2_cls == CLS_DATA);
            hsync_o <= s2_hs;
            vsync_o <= s2_vs;
        end
    end

endmodule

// File: doc/tmds_video_tx.md
Name: tmds_video_tx

Overview:
- Generates DVI/HDMI video timing and a TMDS-encoded 30-bit symbol stream (3 channels × 10 bits) for the HDMI TX serializers.
- Transmit-side counterpart of our capture path, which decodes control tokens, video guard bands and TMDS pixels back into pvalid/vsync/RGB.
- Per line and frame it emits control tokens carrying hsync/vsync, video preamble, video guard band, then DC-balanced 8b/10b pixel data.
- Pixels are fetched from an upstream frame source through a fixed-latency request interface.

Parameters:
H_ACTIVE 1280 active pixels per line
H_FP 110 horizontal front porch (cycles)
H_SYNC 40 hsync width
H_BP 220 horizontal back porch; must be >= 10
V_ACTIVE 720 active lines
V_FP 5 vertical front porch (lines)
V_SYNC 5 vsync width (lines)
V_BP 20 vertical back porch (lines)
HS_POL 1 hsync active level
VS_POL 1 vsync active level

Ports:
clk in 1 pixel clock
rst_n in 1 asynchronous active-low reset
en in 1 timing enable; sampled at line start (hcnt==0)
rgb in 24 pixel {R[23:16],G[15:8],B[7:0]}; valid the cycle after pix_req
pix_req out 1 pixel fetch strobe, one per active pixel
pix_x out 16 column of requested pixel
pix_y out 16 row of requested pixel
frame_start out 1 1-cycle pulse at hcnt==0, vcnt==0
tmds out 30 symbols; ch n at [10n+:10]; ch0 = B, ch1 = G, ch2 = R
de_o out 1 data-enable, aligned with tmds
hsync_o out 1 hsync, aligned with tmds
vsync_o out 1 vsync, aligned with tmds

Behaviour:
- Timing counters:
  - hcnt runs 0..HT-1, HT = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - vcnt runs 0..VT-1 and increments on hcnt wrap.
  - Order: active, FP, sync, BP; active region is hcnt<H_ACTIVE and vcnt<V_ACTIVE.
- en:
  - Sampled only at hcnt==0.
  - If low, counters hold at 0,0 and output stays control tokens with syncs inactive.
  - Deasserting en mid-line finishes the line first; it never truncates.
- Fetch: pix_req=1 in the cycle preceding each active pixel, with pix_x=hcnt and pix_y=vcnt. rgb is sampled one cycle later.
- Latency: counter state at cycle N appears on tmds/de_o/hsync_o/vsync_o at N+3. All control signals are pipelined alongside the data.
- Period classes per line (pipeline stage 2):
  - Video data: de=1; TMDS-encoded pixel.
  - Guard band: the 2 cycles before active, on active lines only. ch0 = ch2 = 10'b1011001100, ch1 = 10'b0100110011.
  - Preamble: the 8 cycles before the guard band, on active lines only. ch0 carries syncs. ch1 uses CTL {c1,c0}=01 → 10'b0010101011; ch2 uses 00.
  - Control: all other cycles. Each channel sends token{c1,c0}: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011. ch0 {c1,c0} = {vsync,hsync}; ch1 and ch2 use 00.
- Sync levels:
  - hsync = HS_POL during H_SYNC cycles, else ~HS_POL.
  - vsync = VS_POL for lines V_ACTIVE+V_FP .. +V_SYNC-1, else ~VS_POL.
  - vsync toggles at hcnt==0.
- TMDS encode (per channel, DVI 1.0):
  - Stage 1: N1(D) > 4, or N1(D) == 4 with D[0] == 0, selects the XNOR chain; otherwise XOR. Produces q_m[8:0].
  - Stage 2: DC balance with signed 5-bit disparity cnt (even values).
  - cnt is cleared to 0 on every non-data cycle, including guard band and preamble.
  - Invariant: |cnt| <= 10 at all times.
- Reset (async assert, sync release via 2-flop synchronizer on rst_n):
  - hcnt = vcnt = 0 and cnt = 0.
  - pix_req = 0, frame_start = 0, de_o = 0.
  - hsync_o = ~HS_POL, vsync_o = ~VS_POL.
  - tmds = {3{10'b1101010100}} for HS_POL = VS_POL = 1 (control with syncs inactive).
- Reset mid-line: restarts at 0,0 with no partial symbol; the first post-reset frame_start comes once en is seen high.
- frame_start is emitted in counter domain (N) and is not pipeline-delayed.

Test Plan:
- Small timing (H_ACTIVE 4, H_FP 2, H_SYNC 2, H_BP 12, V_ACTIVE 2, V_FP 1, V_SYNC 1, V_BP 1), en=1 → HT=20, VT=5; frame_start every 100 cycles; exactly 8 pix_req per frame with (x,y) = (0..3, 0..1).
- Same config, active line → tmds shows 8 preamble symbols (ch1=0010101011), then 2 guard symbols (ch0=1011001100, ch1=0100110011), then 4 de_o=1 symbols, all 3 cycles after the matching counter state.
- rgb=0x000000 constant → each channel's first active symbol is 10'h100, second 10'h3FF; cnt returns to 0 at next blank; bench model checks |cnt| <= 10.
- Random rgb vs reference TMDS model over 3 frames → bit-exact symbols; decoding ch0 tokens gives hsync/vsync matching hsync_o/vsync_o.
- en=0 from reset → tmds constant 3×1101010100, no pix_req; en raised mid-line → frame_start at the next hcnt==0 sample.
- rst_n pulsed low mid-active-line → outputs take reset values immediately (asynchronously); after release plus 2 cycles, counting restarts at 0,0.
